// File: rtl/euclid_dcme_cell_pkg.sv
// Shared defaults for the DCME key-equation cell and the per-frame delta update.
package euclid_dcme_cell_pkg;

  localparam int          M_DEF         = 13;
  localparam logic [12:0] POLY_DEF      = 13'h001B;
  localparam int          FRAME_LEN_DEF = 24;
  localparam int          DW_DEF        = 6;

  // -d-1 equals ~d in two's complement; the caller truncates to its delta width.
  function automatic logic [31:0] delta_update(input logic [31:0] d,
                                               input logic        stop,
                                               input logic        swap);
    if (stop)
      return d;
    else if (swap)
      return ~d;
    else
      return d - 32'd1;
  endfunction

endpackage

// File: rtl/euclid_dcme_cell_gf_mult.sv
// Combinational GF(2^M) multiplier: shift-and-add with on-the-fly reduction.
module euclid_dcme_cell_gf_mult
  import euclid_dcme_cell_pkg::*;
#(
  parameter int          M    = M_DEF,
  parameter logic [M-1:0] POLY = M'(POLY_DEF)
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p
);

  logic [M-1:0] acc;
  logic [M-1:0] sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i])
        acc = acc ^ sh;
      sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? POLY : '0);
    end
    p = acc;
  end

endmodule

// File: rtl/euclid_dcme_cell.sv
// One DCME iteration: per-frame swap/stop decision, GF cross-multiply and
// one-beat shift of R/L, emitted three cycles after each non-leading input beat.
module euclid_dcme_cell
  import euclid_dcme_cell_pkg::*;
#(
  parameter int           M         = M_DEF,
  parameter logic [M-1:0] POLY      = M'(POLY_DEF),
  parameter int           FRAME_LEN = FRAME_LEN_DEF,
  parameter int           DW        = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [M-1:0]  rin,
  input  logic [M-1:0]  qin,
  input  logic [M-1:0]  lin,
  input  logic [M-1:0]  uin,
  input  logic [DW-1:0] delta_in,
  input  logic          stop_in,
  output logic          out_valid,
  output logic          out_sof,
  output logic [M-1:0]  rout,
  output logic [M-1:0]  qout,
  output logic [M-1:0]  lout,
  output logic [M-1:0]  uout,
  output logic [DW-1:0] delta_out,
  output logic          stop_out,
  output logic          frame_err
);

  localparam int          CW   = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;
  logic          tail_pend;
  logic [M-1:0]  hl_r, hl_q;
  logic          h_stop, h_swap;
  logic [DW-1:0] h_dout;

  logic sof_beat, dat_beat, stray, mid_sof, last_beat, swap_now;
  logic [DW-1:0] dout_now;

  assign sof_beat  = in_valid & in_sof;
  assign dat_beat  = in_valid & ~in_sof & (cnt != '0);
  assign stray     = in_valid & ~in_sof & (cnt == '0);
  assign mid_sof   = sof_beat & (cnt != '0);
  assign last_beat = dat_beat & (cnt == LAST);
  assign swap_now  = ~stop_in & (rin != '0) & delta_in[DW-1];
  assign dout_now  = DW'(delta_update(32'(delta_in), stop_in, swap_now));

  // Stage A: registered input beat tagged with its frame's decisions.
  logic          a_valid, a_sof, a_first, a_tail, a_err, a_stop, a_swap;
  logic [M-1:0]  a_lr, a_lq, a_r, a_q, a_l, a_u;
  logic [DW-1:0] a_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0; tail_pend <= 1'b0;
      hl_r <= '0; hl_q <= '0; h_stop <= 1'b0; h_swap <= 1'b0; h_dout <= '0;
      a_valid <= 1'b0; a_sof <= 1'b0; a_first <= 1'b0; a_tail <= 1'b0;
      a_err <= 1'b0; a_stop <= 1'b0; a_swap <= 1'b0;
      a_lr <= '0; a_lq <= '0; a_r <= '0; a_q <= '0; a_l <= '0; a_u <= '0;
      a_dout <= '0;
    end else begin
      a_valid   <= sof_beat | dat_beat;
      a_sof     <= sof_beat;
      a_first   <= dat_beat & (cnt == ONE);
      a_err     <= mid_sof | stray;
      tail_pend <= last_beat;
      a_tail    <= tail_pend;
      a_r <= rin; a_q <= qin; a_l <= lin; a_u <= uin;
      a_lr <= hl_r; a_lq <= hl_q;
      if (sof_beat) begin
        cnt    <= ONE;
        hl_r   <= rin;
        hl_q   <= qin;
        h_stop <= stop_in;
        h_swap <= swap_now;
        h_dout <= dout_now;
        a_stop <= stop_in;
        a_swap <= swap_now;
        a_dout <= dout_now;
      end else begin
        a_stop <= h_stop;
        a_swap <= h_swap;
        a_dout <= h_dout;
        if (dat_beat)
          cnt <= last_beat ? '0 : cnt + ONE;
      end
    end
  end

  logic [M-1:0] m_lr_q, m_lq_r, m_lr_u, m_lq_l;

  euclid_dcme_cell_gf_mult #(.M(M), .POLY(POLY)) u_mul_rq (.a(a_lr), .b(a_q), .p(m_lr_q));
  euclid_dcme_cell_gf_mult #(.M(M), .POLY(POLY)) u_mul_qr (.a(a_lq), .b(a_r), .p(m_lq_r));
  euclid_dcme_cell_gf_mult #(.M(M), .POLY(POLY)) u_mul_ru (.a(a_lr), .b(a_u), .p(m_lr_u));
  euclid_dcme_cell_gf_mult #(.M(M), .POLY(POLY)) u_mul_ql (.a(a_lq), .b(a_l), .p(m_lq_l));

  // Stage B: the R'/L' sums are symmetric, so swap only steers which lanes
  // feed Q'/U'. The p_* registers hold the previous beat already in output form.
  logic          b_valid, b_sof, b_err, b_stop;
  logic [M-1:0]  b_r, b_q, b_l, b_u;
  logic [DW-1:0] b_dout;
  logic [M-1:0]  p_r, p_q, p_l, p_u;

  always_ff @(posedge clk) begin
    if (reset) begin
      b_valid <= 1'b0; b_sof <= 1'b0; b_err <= 1'b0; b_stop <= 1'b0;
      b_r <= '0; b_q <= '0; b_l <= '0; b_u <= '0; b_dout <= '0;
      p_r <= '0; p_q <= '0; p_l <= '0; p_u <= '0;
    end else begin
      b_valid <= (a_valid & ~a_sof) | a_tail;
      b_sof   <= a_first;
      b_err   <= a_err;
      b_stop  <= a_stop;
      b_dout  <= a_dout;
      b_q     <= p_q;
      b_u     <= p_u;
      b_r     <= (a_tail | a_stop) ? p_r : (m_lr_q ^ m_lq_r);
      b_l     <= (a_tail | a_stop) ? p_l : (m_lr_u ^ m_lq_l);
      if (a_valid) begin
        p_r <= a_stop ? a_r : '0;
        p_l <= a_stop ? a_l : '0;
        p_q <= a_swap ? a_r : a_q;
        p_u <= a_swap ? a_l : a_u;
      end
    end
  end

  // Stage C and output registers.
  logic          c_valid, c_sof, c_err, c_stop;
  logic [M-1:0]  c_r, c_q, c_l, c_u;
  logic [DW-1:0] c_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_valid <= 1'b0; c_sof <= 1'b0; c_err <= 1'b0; c_stop <= 1'b0;
      c_r <= '0; c_q <= '0; c_l <= '0; c_u <= '0; c_dout <= '0;
      out_valid <= 1'b0; out_sof <= 1'b0; frame_err <= 1'b0;
      rout <= '0; qout <= '0; lout <= '0; uout <= '0;
      delta_out <= '0; stop_out <= 1'b0;
    end else begin
      c_valid <= b_valid; c_sof <= b_sof; c_err <= b_err; c_stop <= b_stop;
      c_r <= b_r; c_q <= b_q; c_l <= b_l; c_u <= b_u; c_dout <= b_dout;
      out_valid <= c_valid;
      out_sof   <= c_valid & c_sof;
      frame_err <= c_err;
      rout <= c_valid ? c_r : '0;
      qout <= c_valid ? c_q : '0;
      lout <= c_valid ? c_l : '0;
      uout <= c_valid ? c_u : '0;
      if (c_valid & c_sof) begin
        delta_out <= c_dout;
        stop_out  <= c_stop;
      end
    end
  end

endmodule

// File: tb/tb_euclid_dcme_cell.sv
// Self-checking bench: frames are scored against a per-cycle table built from
// a polynomial-level model of one DCME iteration.
module tb_euclid_dcme_cell;

  localparam int M  = 13;
  localparam int F  = 24;
  localparam int DW = 6;
  localparam int NC = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_sof, stop_in;
  logic [M-1:0]  rin, qin, lin, uin;
  logic [DW-1:0] delta_in;
  logic          out_valid, out_sof, stop_out, frame_err;
  logic [M-1:0]  rout, qout, lout, uout;
  logic [DW-1:0] delta_out;

  euclid_dcme_cell dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .rin(rin), .qin(qin), .lin(lin), .uin(uin),
    .delta_in(delta_in), .stop_in(stop_in),
    .out_valid(out_valid), .out_sof(out_sof),
    .rout(rout), .qout(qout), .lout(lout), .uout(uout),
    .delta_out(delta_out), .stop_out(stop_out), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Polynomial product, then reduction by x^13+x^4+x^3+x+1.
  function automatic logic [12:0] gmul(input logic [12:0] a, input logic [12:0] b);
    logic [25:0] p;
    p = '0;
    for (int i = 0; i < 13; i++)
      if (b[i]) p = p ^ (26'(a) << i);
    for (int i = 25; i >= 13; i--)
      if (p[i]) p = p ^ (26'(14'h201B) << (i - 13));
    return p[12:0];
  endfunction

  // Expected outputs indexed by the clock edge after which they are visible.
  logic          ev[NC], esof[NC], eerr[NC], es[NC];
  logic [M-1:0]  er[NC], eq[NC], el[NC], eu[NC];
  logic [DW-1:0] ed[NC];

  logic [M-1:0]  fr_r[F], fr_q[F], fr_l[F], fr_u[F];
  logic [DW-1:0] fr_d;
  logic          fr_s;
  logic [M-1:0]  ex_r[F], ex_q[F], ex_l[F], ex_u[F];
  logic [DW-1:0] ex_d;
  logic          frame_open = 1'b0;
  logic          mon_en = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_from(input int t0);
    for (int t = t0; t < NC; t++) begin
      ev[t] = 0; esof[t] = 0; eerr[t] = 0; es[t] = 0;
      er[t] = 0; eq[t] = 0; el[t] = 0; eu[t] = 0; ed[t] = 0;
    end
  endtask

  task automatic model_frame();
    logic sw;
    logic [M-1:0] rp[F], lp[F];
    sw = !fr_s && (fr_r[0] != 0) && ($signed(fr_d) < 0);
    for (int i = 0; i < F; i++) begin
      rp[i] = gmul(fr_r[0], fr_q[i]) ^ gmul(fr_q[0], fr_r[i]);
      lp[i] = gmul(fr_r[0], fr_u[i]) ^ gmul(fr_q[0], fr_l[i]);
    end
    for (int j = 0; j < F; j++) begin
      if (fr_s) begin
        ex_r[j] = fr_r[j]; ex_q[j] = fr_q[j]; ex_l[j] = fr_l[j]; ex_u[j] = fr_u[j];
      end else begin
        ex_r[j] = (j < F - 1) ? rp[j + 1] : '0;
        ex_l[j] = (j < F - 1) ? lp[j + 1] : '0;
        ex_q[j] = sw ? fr_r[j] : fr_q[j];
        ex_u[j] = sw ? fr_l[j] : fr_u[j];
      end
    end
    if (fr_s)    ex_d = fr_d;
    else if (sw) ex_d = 6'd0 - fr_d - 6'd1;
    else         ex_d = fr_d - 6'd1;
  endtask

  task automatic put_out(input int t, input int j);
    ev[t] = 1; esof[t] = (j == 0);
    er[t] = ex_r[j]; eq[t] = ex_q[j]; el[t] = ex_l[j]; eu[t] = ex_u[j];
    ed[t] = ex_d; es[t] = fr_s;
  endtask

  task automatic rand_frame(input logic [DW-1:0] d, input logic s);
    for (int i = 0; i < F; i++) begin
      fr_r[i] = M'($urandom_range(8191)); fr_q[i] = M'($urandom_range(8191));
      fr_l[i] = M'($urandom_range(8191)); fr_u[i] = M'($urandom_range(8191));
    end
    fr_d = d; fr_s = s;
  endtask

  task automatic drive_frame(input int gap_pct, input int n_beats);
    int e;
    model_frame();
    for (int k = 0; k < n_beats; k++) begin
      if (k > 0)
        for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
          in_valid = 0; in_sof = 0; tick();
        end
      in_valid = 1; in_sof = (k == 0);
      rin = fr_r[k]; qin = fr_q[k]; lin = fr_l[k]; uin = fr_u[k];
      delta_in = (k == 0) ? fr_d : DW'($urandom_range(63));
      stop_in  = (k == 0) ? fr_s : 1'($urandom_range(1));
      tick();
      e = cyc;
      if (k == 0) begin
        if (frame_open) eerr[e + 3] = 1;
        frame_open = 1;
      end else begin
        put_out(e + 3, k - 1);
      end
      if (k == F - 1) begin
        put_out(e + 4, F - 1);
        frame_open = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 0; in_sof = 0;
    repeat (n) tick();
  endtask

  always @(negedge clk) begin
    if (mon_en && cyc < NC) begin
      check_eq("out_valid", out_valid, ev[cyc]);
      check_eq("out_sof", out_sof, esof[cyc]);
      check_eq("frame_err", frame_err, eerr[cyc]);
      if (ev[cyc]) begin
        check_eq("rout", rout, er[cyc]);
        check_eq("qout", qout, eq[cyc]);
        check_eq("lout", lout, el[cyc]);
        check_eq("uout", uout, eu[cyc]);
        check_eq("delta_out", delta_out, ed[cyc]);
        check_eq("stop_out", stop_out, es[cyc]);
      end
    end
  end

  initial begin
    clear_from(0);
    reset = 1; in_valid = 0; in_sof = 0; stop_in = 0;
    rin = 0; qin = 0; lin = 0; uin = 0; delta_in = 0;
    tick();
    mon_en = 1;
    tick(); tick();
    check_eq("rst_rout", rout, 0);
    check_eq("rst_delta_out", delta_out, 0);
    check_eq("rst_stop_out", stop_out, 0);
    reset = 0;
    idle(2);

    // Stop frame passes through unshifted.
    rand_frame(6'd5, 1'b1);
    for (int i = 0; i < F; i++) begin fr_r[i] = M'(i + 1); fr_q[i] = M'(i + 100); end
    drive_frame(0, F); idle(3);

    // No swap: positive delta.
    rand_frame(6'd2, 1'b0);
    for (int i = 0; i < F; i++) begin
      fr_r[i] = M'(i + 1); fr_q[i] = M'(2 * i + 1); fr_l[i] = 0; fr_u[i] = 0;
    end
    drive_frame(0, F); idle(3);

    // Swap: negative delta with nonzero lead.
    rand_frame(6'h3F, 1'b0);
    fr_r[0] = 13'd2; fr_q[0] = 13'd1;
    drive_frame(0, F); idle(3);

    // Zero R lead suppresses the swap.
    rand_frame(6'h3D, 1'b0);
    fr_r[0] = 13'd0; fr_q[0] = 13'd7;
    drive_frame(0, F); idle(2);

    // Back-to-back random frames, then one with gaps.
    rand_frame(DW'($urandom_range(63)), 1'b0);
    drive_frame(0, F);
    rand_frame(DW'($urandom_range(63)), 1'($urandom_range(3) == 0));
    drive_frame(0, F);
    rand_frame(DW'($urandom_range(63)), 1'b0);
    drive_frame(35, F); idle(4);

    // Mid-frame sof at cnt=10, then a complete frame.
    rand_frame(6'h3A, 1'b0);
    drive_frame(0, 10);
    rand_frame(6'h38, 1'b0);
    drive_frame(20, F); idle(3);

    // Stray non-sof beat while idle.
    in_valid = 1; in_sof = 0; rin = 13'h155;
    tick();
    eerr[cyc + 3] = 1;
    idle(4);

    // Reset at cnt=12 discards the partial frame.
    rand_frame(6'h07, 1'b0);
    drive_frame(0, 12);
    in_valid = 0; in_sof = 0;
    clear_from(cyc + 1);
    reset = 1;
    tick(); tick();
    reset = 0;
    frame_open = 0;
    check_eq("mid_rst_rout", rout, 0);
    check_eq("mid_rst_delta_out", delta_out, 0);
    idle(6);

    // Recovery frame.
    rand_frame(DW'($urandom_range(63)), 1'b0);
    fr_r[0] = 13'h0F0;
    drive_frame(10, F);
    idle(8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
